bus_seq_checker: RTL and testbench
==================================

// Module: bus_seq_checker
// PURPOSE
//  Receive end of the bus interface: consumes an array of bus.s lanes driven by a
//  free-running counter source and checks each lane's stream.
//  Per lane: d must increment by 1 every clk (16-bit wrap), and vld must equal d[0].
//  Per-lane lock FSM, saturating error counters and a sticky cross-lane mismatch flag.
//  Instantiated beside the source in loopback/self-test tops; outputs go to status regs.
// PARAMETERS
//  N_LANES    2   number of bus lanes checked (1-D array)
//  DW         16  bus data width, must match the interface
//  LOCK_COUNT 4   consecutive good samples required to enter LOCK (1..255)
//  ERR_CNT_W  16  width of each per-lane error counter
// PORTS
//  clk            in   1                  clock; also the clk of every bus_in instance
//  rst            in   1                  reset, asynchronous, active-high
//  bus_in         in   bus.s[N_LANES]     lanes to check (d[DW-1:0], vld)
//  clr            in   1                  sync clear of err_cnt and lane_mismatch
//  locked         out  [N_LANES]          lane i FSM is in LOCK
//  err_cnt        out  [N_LANES][ERR_CNT_W] per-lane error count, saturating
//  lane_mismatch  out  1                  sticky: locked lanes carried different d
// BEHAVIOUR
//  - One clock domain; reset is asynchronous and active-high (rst), clock is clk.
//  - rst asserted: FSM=SEARCH, good=0, exp=0, locked=0, err_cnt=0, lane_mismatch=0;
//    takes effect immediately with no clk edge, and mid-operation too.
//  - Every posedge is a sample; no back-pressure, the source free-runs.
//  - sample_ok = (d == exp) && (vld == d[0]). exp <= d + 1 (mod 2^DW) every cycle, all states.
//  - FSM per lane, states: SEARCH -> ACQ -> LOCK.
//    SEARCH: first sample after reset only captures exp; next state ACQ, good=0.
//    ACQ: sample_ok -> good++; at good == LOCK_COUNT go to LOCK. !sample_ok -> good=0,
//         stay ACQ. No errors are counted in ACQ.
//    LOCK: sample_ok -> stay. !sample_ok -> err_cnt++, go to ACQ, good=0.
//  - locked is registered FSM==LOCK. After rst release with a clean stream:
//    edge 1 = SEARCH capture; edges 2..LOCK_COUNT+1 = matches; locked=1 after edge
//    LOCK_COUNT+1. On a bad sample, locked falls after that same edge.
//  - Wrap: 0xFFFF followed by 0x0000 is a good sample. No error.
//  - err_cnt saturates at all-ones and holds there.
//  - lane_mismatch: set when all lanes are in LOCK at a sample and any lane's d != lane 0's d.
//    Evaluated on pre-update state. Cleared only by clr or rst.
//  - clr: err_cnt and lane_mismatch go to 0 at the next edge. clr wins over a
//    simultaneous error or mismatch, so that event is lost. clr does not affect FSM or locked.
//  - N_LANES == 1: lane_mismatch is never set.
//  - All outputs are registered; combinational paths from bus_in to outputs are forbidden.
// TESTING
//  1. rst, then d = 0,1,2,... with vld = d[0] on 2 lanes -> locked = 2'b11 after edge 5;
//     err_cnt = 0 and lane_mismatch = 0 for 1000 cycles.
//  2. Start at d = 0xFFFA and run through 0x0005 after lock -> no error; locked stays 1.
//  3. Lane 1 skips 0x0010 -> 0x0012 while locked -> err_cnt[1] = 1, locked[1] = 0 after
//     that edge, lane_mismatch = 1, locked[1] = 1 again 4 edges later; lane 0 unaffected.
//  4. Lane 0 has d = 0x0021 with vld = 0 (parity error) while locked -> err_cnt[0] = 1
//     and relock; a parity error during ACQ only resets good.
//  5. ERR_CNT_W = 4: inject 20 errors, each spaced to allow relock -> err_cnt = 15 held.
//     clr together with the 21st error -> err_cnt = 0.
//  6. Assert rst between edges while locked with err_cnt = 3 -> all outputs are 0
//     before the next edge; after release, relock follows the timing in scenario 1.

Source files
------------

// File: rtl/bus_seq_checker_if.sv
// One lane of the counter loopback bus: a data word and a valid bit.
// The valid bit carries the data parity, so vld == d[0] on a healthy lane.
interface bus #(
    parameter int DW = 16
) ();
    logic [DW-1:0] d;
    logic          vld;

    modport m (output d, output vld);
    modport s (input d, input vld);
endinterface

// File: rtl/bus_seq_checker.sv
// Receive-side checker for free-running counter lanes: per-lane lock FSM,
// saturating error counters and a sticky cross-lane data mismatch flag.
module bus_seq_checker #(
    parameter int N_LANES    = 2,
    parameter int DW         = 16,
    parameter int LOCK_COUNT = 4,
    parameter int ERR_CNT_W  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    bus.s                                       bus_in [N_LANES],
    input  logic                                clr,
    output logic [N_LANES-1:0]                  locked,
    output logic [N_LANES-1:0][ERR_CNT_W-1:0]   err_cnt,
    output logic                                lane_mismatch
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ACQ    = 2'd1,
        LOCK   = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_GOOD = 8'(LOCK_COUNT);

    logic [DW-1:0]      lane_d [N_LANES];
    logic [N_LANES-1:0] lane_lock;
    logic               lanes_differ;
    logic               mismatch_hit;

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        state_t               state;
        state_t               state_nxt;
        logic [7:0]           good;
        logic [7:0]           good_nxt;
        logic [DW-1:0]        exp_d;
        logic [ERR_CNT_W-1:0] errs;
        logic                 sample_ok;
        logic                 err_hit;

        assign lane_d[i]  = bus_in[i].d;
        assign sample_ok  = (bus_in[i].d == exp_d) && (bus_in[i].vld == bus_in[i].d[0]);

        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        always_comb begin
            state_nxt = state;
            good_nxt  = good;
            err_hit   = 1'b0;
            case (state)
                SEARCH: begin
                    state_nxt = ACQ;
                    good_nxt  = '0;
                end
                ACQ: begin
                    if (!sample_ok) begin
                        good_nxt = '0;
                    end else if (good + 8'd1 == LOCK_GOOD) begin
                        state_nxt = LOCK;
                        good_nxt  = '0;
                    end else begin
                        good_nxt = good + 8'd1;
                    end
                end
                LOCK: begin
                    if (!sample_ok) begin
                        state_nxt = ACQ;
                        good_nxt  = '0;
                        err_hit   = 1'b1;
                    end
                end
                default: begin
                    state_nxt = SEARCH;
                    good_nxt  = '0;
                end
            endcase
        end

        // NOTE: sequential state uses non-blocking assignments so all lanes see pre-edge values.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= SEARCH;
                good  <= '0;
                exp_d <= '0;
            end else begin
                state <= state_nxt;
                good  <= good_nxt;
                // Expectation re-seeds from the received word, so one slip costs one error.
                exp_d <= bus_in[i].d + DW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                errs <= '0;
            end else if (clr) begin
                errs <= '0;
            end else if (err_hit && !(&errs)) begin
                errs <= errs + ERR_CNT_W'(1);
            end
        end

        assign lane_lock[i] = (state == LOCK);
        assign locked[i]    = lane_lock[i];
        assign err_cnt[i]   = errs;
    end

    always_comb begin
        lanes_differ = 1'b0;
        for (int i = 1; i < N_LANES; i++) begin
            if (lane_d[i] != lane_d[0]) lanes_differ = 1'b1;
        end
        mismatch_hit = (&lane_lock) && lanes_differ;
    end

    // clr has priority, so a mismatch seen on the clearing edge is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_mismatch <= 1'b0;
        end else if (clr) begin
            lane_mismatch <= 1'b0;
        end else if (mismatch_hit) begin
            lane_mismatch <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_seq_checker.sv
// Directed bench for bus_seq_checker: a 2-lane default instance and a 1-lane
// instance with 4-bit error counters, checked through an expectation queue.
module tb_bus_seq_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clr;
    logic        clr4;
    logic [15:0] d0, d1, d4;
    logic        v0, v1, v4;

    logic [1:0]        locked;
    logic [1:0][15:0]  err_cnt;
    logic              lane_mismatch;
    logic [0:0]        locked4;
    logic [0:0][3:0]   err_cnt4;
    logic              lane_mismatch4;

    bus #(.DW(16)) lanes [2] ();
    bus #(.DW(16)) lane4 [1] ();

    assign lanes[0].d   = d0;
    assign lanes[0].vld = v0;
    assign lanes[1].d   = d1;
    assign lanes[1].vld = v1;
    assign lane4[0].d   = d4;
    assign lane4[0].vld = v4;

    bus_seq_checker #(
        .N_LANES(2), .DW(16), .LOCK_COUNT(4), .ERR_CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .bus_in(lanes), .clr(clr),
        .locked(locked), .err_cnt(err_cnt), .lane_mismatch(lane_mismatch)
    );

    bus_seq_checker #(
        .N_LANES(1), .DW(16), .LOCK_COUNT(4), .ERR_CNT_W(4)
    ) dut4 (
        .clk(clk), .rst(rst), .bus_in(lane4), .clr(clr4),
        .locked(locked4), .err_cnt(err_cnt4), .lane_mismatch(lane_mismatch4)
    );

    typedef struct {
        string       tag;
        bit          sel;   // 0: two-lane instance, 1: narrow-counter instance
        logic [1:0]  xl;
        logic [15:0] xe0;
        logic [15:0] xe1;
        logic        xm;
    } exp_t;

    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            if (!e.sel) begin
                check({e.tag, "_locked"},   32'(locked),        32'(e.xl));
                check({e.tag, "_err0"},     32'(err_cnt[0]),    32'(e.xe0));
                check({e.tag, "_err1"},     32'(err_cnt[1]),    32'(e.xe1));
                check({e.tag, "_mismatch"}, 32'(lane_mismatch), 32'(e.xm));
            end else begin
                check({e.tag, "_locked4"},   32'(locked4),        32'(e.xl[0]));
                check({e.tag, "_err4"},      32'(err_cnt4[0]),    32'(e.xe0));
                check({e.tag, "_mismatch4"}, 32'(lane_mismatch4), 32'd0);
            end
        end
    endtask

    // ok=0 drives the wrong parity on vld for that word.
    task automatic step(input string tag,
                        input logic [15:0] a0, input logic ok0,
                        input logic [15:0] a1, input logic ok1,
                        input logic cl, input logic [1:0] xl,
                        input logic [15:0] xe0, input logic [15:0] xe1, input logic xm);
        exp_t e;
        d0  = a0;
        v0  = ok0 ? a0[0] : ~a0[0];
        d1  = a1;
        v1  = ok1 ? a1[0] : ~a1[0];
        clr = cl;
        e.tag = tag; e.sel = 1'b0; e.xl = xl; e.xe0 = xe0; e.xe1 = xe1; e.xm = xm;
        sb.push_back(e);
        @(posedge clk);
        #1;
        clr = 1'b0;
        compare_next();
    endtask

    task automatic step4(input string tag, input logic [15:0] a, input logic ok,
                         input logic cl, input logic xl, input logic [15:0] xe);
        exp_t e;
        d4   = a;
        v4   = ok ? a[0] : ~a[0];
        clr4 = cl;
        e.tag = tag; e.sel = 1'b1; e.xl = {1'b0, xl}; e.xe0 = xe; e.xe1 = '0; e.xm = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        clr4 = 1'b0;
        compare_next();
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_locked"},    32'(locked),         32'd0);
        check({tag, "_err0"},      32'(err_cnt[0]),     32'd0);
        check({tag, "_err1"},      32'(err_cnt[1]),     32'd0);
        check({tag, "_mismatch"},  32'(lane_mismatch),  32'd0);
        check({tag, "_locked4"},   32'(locked4),        32'd0);
        check({tag, "_err4"},      32'(err_cnt4[0]),    32'd0);
        check({tag, "_mismatch4"}, 32'(lane_mismatch4), 32'd0);
    endtask

    // Called one time unit after an edge: reset acts with no clock edge in between.
    task automatic rst_pulse(input string tag);
        rst = 1'b1;
        #2;
        reset_checks(tag);
        rst = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] a;
        logic [15:0] e;
        rst = 1'b1; clr = 1'b0; clr4 = 1'b0;
        d0 = '0; d1 = '0; d4 = '0; v0 = 1'b0; v1 = 1'b0; v4 = 1'b0;
        #2;
        reset_checks("reset_initial");
        #10;
        rst = 1'b0;

        // Clean aligned streams: locked after the fifth edge, then 1000 quiet cycles.
        for (int k = 0; k < 1005; k++)
            step("s1_clean", 16'(k), 1'b1, 16'(k), 1'b1, 1'b0,
                 (k >= 4) ? 2'b11 : 2'b00, 16'd0, 16'd0, 1'b0);

        // Wrap through 0xFFFF -> 0x0000 after lock, then on up to 0x000F.
        rst_pulse("s2_reset");
        a = 16'hFFFA;
        for (int i = 0; i < 22; i++) begin
            step("s2_wrap", a, 1'b1, a, 1'b1, 1'b0,
                 (i >= 4) ? 2'b11 : 2'b00, 16'd0, 16'd0, 1'b0);
            a++;
        end

        // Lane 1 skips 0x0011; relock four edges later; mismatch is sticky.
        step("s3_skip", 16'h0010, 1'b1, 16'h0012, 1'b1, 1'b0, 2'b01, 16'd0, 16'd1, 1'b1);
        for (int j = 1; j <= 6; j++)
            step("s3_relock", 16'h0010 + 16'(j), 1'b1, 16'h0012 + 16'(j), 1'b1, 1'b0,
                 (j >= 4) ? 2'b11 : 2'b01, 16'd0, 16'd1, 1'b1);
        // clr beats the mismatch present on its own edge; the next edge sets it again.
        step("s3_clr", 16'h0017, 1'b1, 16'h0019, 1'b1, 1'b1, 2'b11, 16'd0, 16'd0, 1'b0);
        step("s3_after_clr", 16'h0018, 1'b1, 16'h001A, 1'b1, 1'b0, 2'b11, 16'd0, 16'd0, 1'b1);

        // Parity error on lane 0 while locked, then another one during ACQ.
        rst_pulse("s4_reset");
        a = 16'h0018;
        for (int i = 0; i < 9; i++) begin
            step("s4_lock", a, 1'b1, a, 1'b1, 1'b0,
                 (i >= 4) ? 2'b11 : 2'b00, 16'd0, 16'd0, 1'b0);
            a++;
        end
        step("s4_par_lock", a, 1'b0, a, 1'b1, 1'b0, 2'b10, 16'd1, 16'd0, 1'b0); a++;
        step("s4_acq", a, 1'b1, a, 1'b1, 1'b0, 2'b10, 16'd1, 16'd0, 1'b0); a++;
        step("s4_par_acq", a, 1'b0, a, 1'b1, 1'b0, 2'b10, 16'd1, 16'd0, 1'b0); a++;
        for (int g = 1; g <= 4; g++) begin
            step("s4_relock", a, 1'b1, a, 1'b1, 1'b0,
                 (g == 4) ? 2'b11 : 2'b10, 16'd1, 16'd0, 1'b0);
            a++;
        end
        // Two more locked errors bring lane 0 to three.
        for (int n = 2; n <= 3; n++) begin
            step("s4_err", a, 1'b0, a, 1'b1, 1'b0, 2'b10, 16'(n), 16'd0, 1'b0); a++;
            for (int g = 1; g <= 4; g++) begin
                step("s4_err_relock", a, 1'b1, a, 1'b1, 1'b0,
                     (g == 4) ? 2'b11 : 2'b10, 16'(n), 16'd0, 1'b0);
                a++;
            end
        end

        // Reset between edges while locked with err_cnt[0] == 3, then relock timing again.
        rst_pulse("s6_reset");
        a = 16'h0100;
        for (int i = 0; i < 8; i++) begin
            step("s6_relock", a, 1'b1, a, 1'b1, 1'b0,
                 (i >= 4) ? 2'b11 : 2'b00, 16'd0, 16'd0, 1'b0);
            a++;
        end

        // 4-bit counter saturates at 15; clr wins over the 21st error.
        rst_pulse("s5_reset");
        a = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            step4("s5_lock", a, 1'b1, 1'b0, (i == 4), 16'd0);
            a++;
        end
        for (int n = 1; n <= 20; n++) begin
            e = (n > 15) ? 16'd15 : 16'(n);
            step4("s5_err", a, 1'b0, 1'b0, 1'b0, e); a++;
            for (int g = 1; g <= 4; g++) begin
                step4("s5_relock", a, 1'b1, 1'b0, (g == 4), e);
                a++;
            end
        end
        step4("s5_clr_err", a, 1'b0, 1'b1, 1'b0, 16'd0); a++;
        for (int g = 1; g <= 4; g++) begin
            step4("s5_clr_relock", a, 1'b1, 1'b0, (g == 4), 16'd0);
            a++;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
